bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter: the reverse path of the two-digit BCD adder datapath. It accepts a packed NDIG-digit BCD value (switch entry or adder result) and produces the equivalent unsigned binary over W clock cycles using reverse double-dabble (shift right, then subtract 3 from any digit ≥ 8). It sits between the BCD entry/adder stage and any binary consumer, such as LEDR readback or arithmetic units, with a Start/Busy/Done handshake and an invalid-digit flag.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd_to_bin_seq.sv | 138 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Purpose : shared types and helpers for the BCD <-> binary conversion blocks.
// Latency : n/a (package only).
// Backpressure: n/a.
//   state_t      - converter FSM encoding (IDLE, CONV, CHECK)
//   DIGIT_MAX    - largest legal BCD digit value
//   bin_width(n) - binary width needed to hold any n-digit decimal value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // $clog2(10**ndig), written as a loop so it elaborates as a constant function
  // without relying on integer power support in every tool.
  function automatic int bin_width(input int ndig);
    int p;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Purpose : one-digit double-dabble correction, out = (in >= 8) ? in - 3 : in.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of the input.
//   din_i  [3:0] - digit value after the shift
//   dout_o [3:0] - corrected digit
module bcd_digit_adj (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  // A digit >= 8 after a right shift means a tens carry of 10 was halved into
  // this position as 8 instead of 5; removing 3 restores the decimal weight.
  assign dout_o = (din_i >= 4'd8) ? (din_i - 4'd3) : din_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Purpose : sequential NDIG-digit BCD to unsigned binary (reverse double-dabble).
// Latency : W+1 cycles from accepting edge for legal input, 1 cycle for illegal input.
// Backpressure: Start sampled only while idle; Start during Busy is dropped, not queued.
//   Clock, Reset (sync, active-high)
//   Start, BCD[4*NDIG-1:0]   - request and packed digits ([3:0] = ones)
//   Bin[W-1:0], Err          - result and invalid-digit flag, updated on Done
//   Busy, Done               - in-progress level and one-cycle completion pulse
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter  int NDIG = 3,
  localparam int W    = bin_width(NDIG)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [4*NDIG-1:0]   BCD,
  output logic [W-1:0]        Bin,
  output logic                Busy,
  output logic                Done,
  output logic                Err
);

  localparam int SW = 4 * NDIG + W;      // shift register: {digits, binary}
  localparam int CW = $clog2(W + 1);     // iteration counter width

  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   sr_q,    sr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [W-1:0]    bin_q,   bin_d;
  logic            err_q,   err_d;
  logic            done_q,  done_d;

  logic [SW-1:0]   sr_shift;
  logic [SW-1:0]   sr_adj;
  logic            digit_bad;

  // --------------------------------------------------------------------------
  // Datapath: shift right by one, then correct every digit in the upper field.
  // The binary field only receives shifted-in bits and is never adjusted.
  // --------------------------------------------------------------------------
  assign sr_shift = sr_q >> 1;
  assign sr_adj[W-1:0] = sr_shift[W-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din_i  (sr_shift[W + 4*g +: 4]),
      .dout_o (sr_adj[W + 4*g +: 4])
    );
  end

  // Validity check runs on the freshly loaded digits while in CHECK.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (sr_q[W + 4*i +: 4] > DIGIT_MAX) begin
        digit_bad = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          sr_d    = {BCD, {W{1'b0}}};
          cnt_d   = '0;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (digit_bad) begin
          // Illegal digit: report immediately, skip the conversion entirely.
          err_d   = 1'b1;
          bin_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CONV;
        end
      end

      CONV: begin
        sr_d  = sr_adj;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Err is cleared here rather than in CHECK so that Bin and Err
          // always move together on the Done edge of the same request.
          bin_d   = sr_adj[W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign Bin  = bin_q;
  assign Err  = err_q;
  assign Done = done_q;
  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Purpose : directed, table-driven check of bcd_to_bin_seq (NDIG=3, W=10).
// Latency : n/a.
// Backpressure: n/a.
module tb_bcd_to_bin_seq;

  localparam int W = 10;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [11:0]   BCD;
  logic [W-1:0]  Bin;
  logic          Busy;
  logic          Done;
  logic          Err;

  int tests  = 0;
  int failed = 0;

  bcd_to_bin_seq #(.NDIG(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .BCD   (BCD),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .Err   (Err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [11:0]  bcd;
    logic [W-1:0] bin;
    logic         err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issue one request; returns edges from accept to Done and Busy samples seen.
  task automatic do_conv(input logic [11:0] bcd, output int lat, output int busy_n);
    BCD   = bcd;
    Start = 1'b1;
    tick();
    Start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!Done && lat < 40) begin
      if (Busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, busy_n, exp_lat, dones, last_done;
    logic prev_done;

    vecs[0]  = '{12'h999, 10'd999, 1'b0};
    vecs[1]  = '{12'h000, 10'd0,   1'b0};
    vecs[2]  = '{12'h128, 10'd128, 1'b0};
    vecs[3]  = '{12'h1A5, 10'd0,   1'b1};
    vecs[4]  = '{12'h042, 10'd42,  1'b0};
    vecs[5]  = '{12'h500, 10'd500, 1'b0};
    vecs[6]  = '{12'h009, 10'd9,   1'b0};
    vecs[7]  = '{12'h0F0, 10'd0,   1'b1};
    vecs[8]  = '{12'h900, 10'd900, 1'b0};
    vecs[9]  = '{12'h00A, 10'd0,   1'b1};
    vecs[10] = '{12'h123, 10'd123, 1'b0};
    vecs[11] = '{12'h512, 10'd512, 1'b0};

    Reset = 1'b1;
    Start = 1'b0;
    BCD   = '0;
    tick();
    tick();
    chk("reset_bin",  int'(Bin),  0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_err",  int'(Err),  0);
    Reset = 1'b0;
    tick();

    // Table-driven conversions; Bin must hold the previous result until Done.
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        chk($sformatf("hold_bin[%0d]", i), int'(Bin), int'(vecs[i-1].bin));
      end
      exp_lat = vecs[i].err ? 1 : 11;
      do_conv(vecs[i].bcd, lat, busy_n);
      chk($sformatf("latency[%0d]", i), lat, exp_lat);
      chk($sformatf("busy_cycles[%0d]", i), busy_n, exp_lat);
      chk($sformatf("bin[%0d]", i), int'(Bin), int'(vecs[i].bin));
      chk($sformatf("err[%0d]", i), int'(Err), int'(vecs[i].err));
      tick();
      chk($sformatf("done_width[%0d]", i), int'(Done), 0);
      chk($sformatf("idle_after[%0d]", i), int'(Busy), 0);
    end

    // Start pulsed again while busy is ignored.
    BCD   = 12'h321;
    Start = 1'b1;
    tick();                       // edge k
    Start = 1'b0;
    tick();                       // k+1
    tick();                       // k+2
    BCD   = 12'h777;
    Start = 1'b1;
    tick();                       // k+3, ignored
    Start = 1'b0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (Done) dones++;
      tick();
    end
    chk("busy_start_dones", dones, 1);
    chk("busy_start_bin", int'(Bin), 321);
    chk("busy_start_err", int'(Err), 0);

    // Reset mid-conversion: everything clears, no Done for the aborted request.
    BCD   = 12'h555;
    Start = 1'b1;
    tick();                       // k
    Start = 1'b0;
    for (int c = 0; c < 4; c++) tick();   // k+1..k+4
    chk("pre_abort_busy", int'(Busy), 1);
    Reset = 1'b1;
    tick();                       // k+5
    Reset = 1'b0;
    chk("abort_bin",  int'(Bin),  0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_done", int'(Done), 0);
    chk("abort_err",  int'(Err),  0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (Done) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);
    do_conv(12'h256, lat, busy_n);
    chk("post_abort_lat", lat, 11);
    chk("post_abort_bin", int'(Bin), 256);

    // Reset and Start on the same edge: Reset wins.
    tick();
    Reset = 1'b1;
    Start = 1'b1;
    BCD   = 12'h111;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    chk("reset_vs_start_busy", int'(Busy), 0);
    chk("reset_vs_start_bin",  int'(Bin),  0);
    tick();

    // Start held high: back-to-back conversions every W+2 cycles.
    BCD       = 12'h500;
    Start     = 1'b1;
    dones     = 0;
    last_done = -1;
    prev_done = 1'b0;
    for (int c = 0; c < 62; c++) begin
      tick();
      if (Done) begin
        dones++;
        chk("held_bin", int'(Bin), 500);
        chk("held_done_width", int'(prev_done), 0);
        if (last_done >= 0) chk("held_period", c - last_done, 12);
        last_done = c;
      end
      prev_done = Done;
    end
    chk("held_done_count", dones, 5);
    Start = 1'b0;
    for (int c = 0; c < 20 && Busy; c++) tick();
    chk("held_drain_busy", int'(Busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
